// File: rtl/jtcop_vtimer.sv
// ============================================================================
//  Module   : jtcop_vtimer
//  Purpose  : Shared video timing source for the BAC06 tile layers, object
//             engine and colour mixer: pixel enables, counters, blanks, syncs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module jtcop_vtimer #(
    parameter int CEN_DIV  = 8,
    parameter int HTOTAL   = 384,
    parameter int HB_START = 256,
    parameter int HS_START = 300,
    parameter int HS_END   = 332,
    parameter int VTOTAL   = 272,
    parameter int VB_END   = 8,
    parameter int VB_START = 248,
    parameter int VS_START = 252,
    parameter int VS_END   = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pxl2_cen,
    output logic       pxl_cen,
    output logic [8:0] hdump,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS,
    output logic       hinit,
    output logic       vload
);

    localparam int               c_CNT_W    = (CEN_DIV > 2) ? $clog2(CEN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_HALF   = c_CNT_W'(CEN_DIV / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(CEN_DIV - 1);
    localparam logic [8:0]       c_H_LAST   = 9'(HTOTAL - 1);
    localparam logic [8:0]       c_V_LAST   = 9'(VTOTAL - 1);
    localparam logic [8:0]       c_HB_START = 9'(HB_START);
    localparam logic [8:0]       c_HS_START = 9'(HS_START);
    localparam logic [8:0]       c_HS_END   = 9'(HS_END);
    localparam logic [8:0]       c_VB_END   = 9'(VB_END);
    localparam logic [8:0]       c_VB_START = 9'(VB_START);
    localparam logic [8:0]       c_VS_START = 9'(VS_START);
    localparam logic [8:0]       c_VS_END   = 9'(VS_END);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_pxl2_cen, r_pxl_cen, r_hinit, r_vload;
    logic [8:0]         r_hdump, r_vdump, r_vrender;
    logic               r_lhbl, r_lvbl, r_hs, r_vs;

    logic               w_adv, w_half, w_h_wrap, w_v_wrap;
    logic [8:0]         w_h_nxt, w_v_nxt, w_vr_nxt;

    // w_adv marks the edge on which pxl_cen rises, so counters and their
    // decodes change on the very cycle pxl_cen is visible downstream.
    assign w_adv    = (r_cnt == c_LAST);
    assign w_half   = (r_cnt == c_HALF);
    assign w_h_wrap = (r_hdump == c_H_LAST);
    assign w_v_wrap = w_h_wrap && (r_vdump == c_V_LAST);
    assign w_h_nxt  = w_h_wrap ? 9'd0 : r_hdump + 9'd1;
    assign w_v_nxt  = w_v_wrap ? 9'd0 : (w_h_wrap ? r_vdump + 9'd1 : r_vdump);
    assign w_vr_nxt = (w_v_nxt == c_V_LAST) ? 9'd0 : w_v_nxt + 9'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_pxl2_cen <= 1'b0;
            r_pxl_cen  <= 1'b0;
            r_hinit    <= 1'b0;
            r_vload    <= 1'b0;
            r_hdump    <= 9'd0;
            r_vdump    <= 9'd0;
            r_vrender  <= 9'd1;
            r_lhbl     <= 1'b0;
            r_lvbl     <= 1'b0;
            r_hs       <= 1'b0;
            r_vs       <= 1'b0;
        end else begin
            r_cnt      <= w_adv ? '0 : r_cnt + 1'b1;
            r_pxl2_cen <= w_adv || w_half;
            r_pxl_cen  <= w_adv;
            r_hinit    <= w_adv && w_h_wrap;
            r_vload    <= w_adv && w_v_wrap;
            if (w_adv) begin
                r_hdump   <= w_h_nxt;
                r_vdump   <= w_v_nxt;
                r_vrender <= w_vr_nxt;
                // Decode the next values so blanks/syncs have zero skew.
                r_lhbl    <= (w_h_nxt < c_HB_START);
                r_lvbl    <= (w_v_nxt >= c_VB_END) && (w_v_nxt < c_VB_START);
                r_hs      <= (w_h_nxt >= c_HS_START) && (w_h_nxt < c_HS_END);
                r_vs      <= (w_v_nxt >= c_VS_START) && (w_v_nxt < c_VS_END);
            end
        end
    end

    assign pxl2_cen = r_pxl2_cen;
    assign pxl_cen  = r_pxl_cen;
    assign hdump    = r_hdump;
    assign vdump    = r_vdump;
    assign vrender  = r_vrender;
    assign LHBL     = r_lhbl;
    assign LVBL     = r_lvbl;
    assign HS       = r_hs;
    assign VS       = r_vs;
    assign hinit    = r_hinit;
    assign vload    = r_vload;

endmodule

`default_nettype wire

// File: tb/tb_jtcop_vtimer.sv
// ============================================================================
//  Module   : tb_jtcop_vtimer
//  Purpose  : Bench for jtcop_vtimer with default, overridden and compact
//             timing instances checked against a closed-form timing model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jtcop_vtimer;

    typedef struct packed {
        logic       pxl2;
        logic       pxl;
        logic [8:0] h;
        logic [8:0] v;
        logic [8:0] vr;
        logic       lhbl;
        logic       lvbl;
        logic       hs;
        logic       vs;
        logic       hinit;
        logic       vload;
    } vt_t;

    typedef struct {
        int d, ht, vt, hb, hss, hse, vbe, vbs, vss, vse;
    } prm_t;

    logic clk;
    logic rst_n;

    logic       def_pxl2, def_pxl, def_lhbl, def_lvbl, def_hs, def_vs, def_hinit, def_vload;
    logic [8:0] def_h, def_v, def_vr;
    logic       ovr_pxl2, ovr_pxl, ovr_lhbl, ovr_lvbl, ovr_hs, ovr_vs, ovr_hinit, ovr_vload;
    logic [8:0] ovr_h, ovr_v, ovr_vr;
    logic       sml_pxl2, sml_pxl, sml_lhbl, sml_lvbl, sml_hs, sml_vs, sml_hinit, sml_vload;
    logic [8:0] sml_h, sml_v, sml_vr;

    jtcop_vtimer u_def (
        .clk(clk), .rst_n(rst_n), .pxl2_cen(def_pxl2), .pxl_cen(def_pxl),
        .hdump(def_h), .vdump(def_v), .vrender(def_vr), .LHBL(def_lhbl),
        .LVBL(def_lvbl), .HS(def_hs), .VS(def_vs), .hinit(def_hinit), .vload(def_vload)
    );

    jtcop_vtimer #(.CEN_DIV(4), .HTOTAL(320), .VTOTAL(262)) u_ovr (
        .clk(clk), .rst_n(rst_n), .pxl2_cen(ovr_pxl2), .pxl_cen(ovr_pxl),
        .hdump(ovr_h), .vdump(ovr_v), .vrender(ovr_vr), .LHBL(ovr_lhbl),
        .LVBL(ovr_lvbl), .HS(ovr_hs), .VS(ovr_vs), .hinit(ovr_hinit), .vload(ovr_vload)
    );

    // Compact raster so whole frames and the frame wrap fit a short run.
    jtcop_vtimer #(.CEN_DIV(2), .HTOTAL(24), .HB_START(16), .HS_START(18), .HS_END(20),
                   .VTOTAL(20), .VB_END(2), .VB_START(16), .VS_START(17), .VS_END(18)) u_sml (
        .clk(clk), .rst_n(rst_n), .pxl2_cen(sml_pxl2), .pxl_cen(sml_pxl),
        .hdump(sml_h), .vdump(sml_v), .vrender(sml_vr), .LHBL(sml_lhbl),
        .LVBL(sml_lvbl), .HS(sml_hs), .VS(sml_vs), .hinit(sml_hinit), .vload(sml_vload)
    );

    vt_t obs_def, obs_ovr, obs_sml;
    assign obs_def = {def_pxl2, def_pxl, def_h, def_v, def_vr, def_lhbl, def_lvbl, def_hs, def_vs, def_hinit, def_vload};
    assign obs_ovr = {ovr_pxl2, ovr_pxl, ovr_h, ovr_v, ovr_vr, ovr_lhbl, ovr_lvbl, ovr_hs, ovr_vs, ovr_hinit, ovr_vload};
    assign obs_sml = {sml_pxl2, sml_pxl, sml_h, sml_v, sml_vr, sml_lhbl, sml_lvbl, sml_hs, sml_vs, sml_hinit, sml_vload};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prm_t p_def, p_ovr, p_sml;
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   k         = 0;   // edges since the last edge that sampled rst_n low
    int   cyc       = 0;
    bit   seen_pxl2, seen_pxl, prev_lhbl, found;
    int   l_pxl2_def, l_pxl_def, l_hi_def, l_pxl_ovr, l_hi_ovr, l_hi_sml, l_vl_sml;
    int   hs_cnt, hi_cnt_def;

    // State after k enabled edges: n pixels elapsed, raster position from n.
    function automatic vt_t model(input int kk, input prm_t p);
        vt_t m;
        int  n, h, v;
        bit  live;
        n      = kk / p.d;
        h      = n % p.ht;
        v      = (n / p.ht) % p.vt;
        live   = (n > 0);
        m.pxl2 = (kk > 0) && (kk % (p.d / 2) == 0);
        m.pxl  = (kk > 0) && (kk % p.d == 0);
        m.h    = 9'(h);
        m.v    = 9'(v);
        m.vr   = 9'((v + 1) % p.vt);
        m.lhbl = live && (h < p.hb);
        m.lvbl = live && (v >= p.vbe) && (v < p.vbs);
        m.hs   = live && (h >= p.hss) && (h < p.hse);
        m.vs   = live && (v >= p.vss) && (v < p.vse);
        m.hinit = m.pxl && live && (h == 0);
        m.vload = m.hinit && (v == 0);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed 0x%0h required 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic spacing(input string tag, input logic ev, inout int last, input int want);
        if (ev) begin
            if (last >= 0) chk(tag, 64'(cyc - last), 64'(want));
            last = cyc;
        end
    endtask

    task automatic clear_trackers();
        seen_pxl2 = 1'b0; seen_pxl = 1'b0; prev_lhbl = 1'b0;
        l_pxl2_def = -1; l_pxl_def = -1; l_hi_def = -1; l_pxl_ovr = -1;
        l_hi_ovr = -1; l_hi_sml = -1; l_vl_sml = -1;
        hs_cnt = 0; hi_cnt_def = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) k = 0;
        else        k++;
        cyc++;
        @(negedge clk);
        chk("def_state", 64'(obs_def), 64'(model(k, p_def)));
        chk("ovr_state", 64'(obs_ovr), 64'(model(k, p_ovr)));
        chk("sml_state", 64'(obs_sml), 64'(model(k, p_sml)));
        if (!rst_n) begin
            clear_trackers();
        end else begin
            if (def_pxl2 && !seen_pxl2) begin
                chk("def_first_pxl2_clk", 64'(k), 64'd4);
                seen_pxl2 = 1'b1;
            end
            if (def_pxl && !seen_pxl) begin
                chk("def_first_pxl_clk", 64'(k), 64'd8);
                chk("def_first_hdump", 64'(def_h), 64'd1);
                seen_pxl = 1'b1;
            end
            spacing("def_pxl2_period", def_pxl2, l_pxl2_def, 4);
            spacing("def_pxl_period", def_pxl, l_pxl_def, 8);
            if (def_hinit) begin
                if (hi_cnt_def > 0) chk("def_hs_width", 64'(hs_cnt), 64'd32);
                hs_cnt = 0;
                hi_cnt_def++;
            end
            if (def_pxl && def_hs) hs_cnt++;
            spacing("def_hinit_period", def_hinit, l_hi_def, 384 * 8);
            if (prev_lhbl && !def_lhbl) chk("def_lhbl_fall_hdump", 64'(def_h), 64'd256);
            if (!prev_lhbl && def_lhbl && hi_cnt_def > 0) chk("def_lhbl_rise_hdump", 64'(def_h), 64'd0);
            prev_lhbl = def_lhbl;
            spacing("ovr_pxl_period", ovr_pxl, l_pxl_ovr, 4);
            spacing("ovr_hinit_period", ovr_hinit, l_hi_ovr, 320 * 4);
            spacing("sml_hinit_period", sml_hinit, l_hi_sml, 24 * 2);
            spacing("sml_vload_period", sml_vload, l_vl_sml, 24 * 20 * 2);
            if (sml_vload)
                chk("sml_frame_wrap", 64'({sml_h, sml_v, sml_vr, sml_hinit, sml_lvbl, sml_lhbl}),
                    64'({9'd0, 9'd0, 9'd1, 1'b1, 1'b0, 1'b1}));
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        p_def = '{8, 384, 272, 256, 300, 332, 8, 248, 252, 256};
        p_ovr = '{4, 320, 262, 256, 300, 332, 8, 248, 252, 256};
        p_sml = '{2, 24, 20, 16, 18, 20, 2, 16, 17, 18};
        clear_trackers();

        rst_n = 1'b0;
        run(10);
        rst_n = 1'b1;
        run(7000);

        // Mid-frame reset on the compact raster at line 10, pixel 15.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (sml_v == 9'd10 && sml_h == 9'd15) found = 1'b1;
            else tick();
        end
        chk("midframe_reach", 64'(found), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("midframe_reset_sml", 64'({sml_h, sml_v, sml_vr}), 64'({9'd0, 9'd0, 9'd1}));
        chk("midframe_reset_def_flags",
            64'({def_pxl2, def_pxl, def_lhbl, def_lvbl, def_hs, def_vs, def_hinit, def_vload}), 64'd0);
        rst_n = 1'b1;
        run(2000);

        // Resets of random length at random phases of all three rasters.
        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(300, 2500)));
            rst_n = 1'b0;
            run(int'($urandom_range(1, 3)));
            rst_n = 1'b1;
        end
        run(3500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
